// File: rtl/mult_seq_32.sv
// rtl/mult_seq_32.sv - sequential unsigned 32x32 shift-add multiplier with HI/LO result
//
// full_adder_32: 32-bit ripple adder built from eight 4-bit stages.
//   A, B  in  32  addends
//   C_I   in  1   carry in
//   S     out 32  sum
//   C_O   out 1   carry out
//
// mult_seq_32: runs one shared full_adder_32 through 32 shift-add iterations.
//   clk     in  1   rising-edge clock
//   reset   in  1   synchronous active-high reset
//   start   in  1   request, sampled when not busy
//   mcand   in  32  multiplicand, sampled with start
//   mplier  in  32  multiplier, sampled with start
//   busy    out 1   operation in progress
//   done    out 1   one-cycle completion pulse
//   hi      out 32  product[63:32]
//   lo      out 32  product[31:0]

module full_adder_32 (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        C_I,
  output logic [31:0] S,
  output logic        C_O
);

  logic [8:0] c;

  assign c[0] = C_I;
  assign C_O  = c[8];

  for (genvar g = 0; g < 8; g++) begin : g_stage
    assign {c[g+1], S[4*g+3:4*g]} = {1'b0, A[4*g+3:4*g]} + {1'b0, B[4*g+3:4*g]} + {4'b0, c[g]};
  end

endmodule

module mult_seq_32 (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] mcand,
  input  logic [31:0] mplier,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      next_state;

  logic [31:0] m_reg;
  logic [63:0] p_reg;
  logic [4:0]  cnt;

  logic        accept;
  logic        step;
  logic        finish;

  logic [31:0] add_b;
  logic [31:0] add_s;
  logic        add_co;
  logic [63:0] p_next;

  // Multiplier bits are consumed from p_reg[0]; the partial sum lives in the
  // upper half and the adder carry becomes its new top bit after the shift.
  assign add_b  = p_reg[0] ? m_reg : 32'h0;
  assign p_next = {add_co, add_s, p_reg[31:1]};

  full_adder_32 u_adder (
    .A   (p_reg[63:32]),
    .B   (add_b),
    .C_I (1'b0),
    .S   (add_s),
    .C_O (add_co)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = start ? RUN : IDLE;
      RUN:     next_state = (cnt == 5'd31) ? DONE : RUN;
      DONE:    next_state = start ? RUN : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state == RUN);
    done   = (state == DONE);
    accept = start && ((state == IDLE) || (state == DONE));
    step   = (state == RUN);
    finish = (state == RUN) && (cnt == 5'd31);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_reg <= 32'h0;
      p_reg <= 64'h0;
      cnt   <= 5'd0;
      hi    <= 32'h0;
      lo    <= 32'h0;
    end else if (accept) begin
      m_reg <= mcand;
      p_reg <= {32'h0, mplier};
      cnt   <= 5'd0;
    end else if (step) begin
      p_reg <= p_next;
      cnt   <= cnt + 5'd1;
      // Result registers are published straight from the last adder pass so
      // hi/lo stay frozen for the whole run.
      if (finish) begin
        hi <= p_next[63:32];
        lo <= p_next[31:0];
      end
    end
  end

endmodule

// File: tb/tb_mult_seq_32.sv
// tb/tb_mult_seq_32.sv - directed self-checking bench for mult_seq_32

module tb_mult_seq_32;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;

  int n;
  bit busy_ok;
  bit stable_ok;
  bit saw_done;

  mult_seq_32 dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .mcand  (mcand),
    .mplier (mplier),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    mcand  = a;
    mplier = b;
    tick();
    start  = 1'b0;
  endtask

  // Called in a RUN cycle with n0 cycles already elapsed since accept; returns
  // the cycle index at which done was seen (40 on timeout).
  task automatic run_to_done(input int n0, output int nc, output bit b_ok, output bit s_ok);
    logic [63:0] hold;
    hold = {hi, lo};
    nc   = n0;
    b_ok = 1'b1;
    s_ok = 1'b1;
    while (!done && nc < 40) begin
      if (busy !== 1'b1) b_ok = 1'b0;
      if ({hi, lo} !== hold) s_ok = 1'b0;
      tick();
      nc++;
    end
  endtask

  task automatic idle_watch(input int cycles, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      tick();
    end
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    mcand  = 32'h0;
    mplier = 32'h0;
    @(negedge clk);
    tick();
    reset = 1'b0;

    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_hilo", {hi, lo}, 64'h0);

    // 3 x 5
    start_op(32'h3, 32'h5);
    check("p1_busy_after_accept", busy, 1'b1);
    run_to_done(0, n, busy_ok, stable_ok);
    check("p1_latency", n, 32);
    check("p1_busy_held", busy_ok, 1'b1);
    check("p1_hilo_stable", stable_ok, 1'b1);
    check("p1_done", done, 1'b1);
    check("p1_busy_low_at_done", busy, 1'b0);
    check("p1_hi", hi, 32'h0);
    check("p1_lo", lo, 32'hF);
    tick();
    check("p1_done_falls", done, 1'b0);
    check("p1_idle_busy", busy, 1'b0);
    check("p1_lo_held", lo, 32'hF);

    // all-ones squared: carry out of every addition matters
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_to_done(0, n, busy_ok, stable_ok);
    check("ff_latency", n, 32);
    check("ff_product", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    tick();

    start_op(32'h8000_0000, 32'h2);
    run_to_done(0, n, busy_ok, stable_ok);
    check("msb_product", {hi, lo}, 64'h0000_0001_0000_0000);
    tick();

    start_op(32'h0, 32'h1234_5678);
    run_to_done(0, n, busy_ok, stable_ok);
    check("zero_product", {hi, lo}, 64'h0);
    check("zero_done", done, 1'b1);
    tick();

    // start during busy is ignored
    start_op(32'd7, 32'd6);
    repeat (9) tick();
    check("sdb_lo_during_run", {hi, lo}, 64'h0);
    start  = 1'b1;
    mcand  = 32'd9;
    mplier = 32'd9;
    tick();
    start  = 1'b0;
    run_to_done(10, n, busy_ok, stable_ok);
    check("sdb_latency", n, 32);
    check("sdb_busy_held", busy_ok, 1'b1);
    check("sdb_hilo_stable", stable_ok, 1'b1);
    check("sdb_product", {hi, lo}, 64'd42);
    tick();
    idle_watch(40, saw_done);
    check("sdb_single_done", saw_done, 1'b0);
    check("sdb_lo_kept", lo, 32'd42);

    // reset aborts an operation in flight
    start_op(32'd2, 32'd3);
    run_to_done(0, n, busy_ok, stable_ok);
    check("rst_pre_product", {hi, lo}, 64'd6);
    tick();
    start_op(32'd100, 32'd100);
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_hilo", {hi, lo}, 64'h0);
    idle_watch(40, saw_done);
    check("rst_no_done", saw_done, 1'b0);
    check("rst_hilo_after", {hi, lo}, 64'h0);

    // back-to-back with start held through the DONE cycle
    start  = 1'b1;
    mcand  = 32'd4;
    mplier = 32'd4;
    tick();
    check("b2b_busy", busy, 1'b1);
    run_to_done(0, n, busy_ok, stable_ok);
    check("b2b1_latency", n, 32);
    check("b2b1_done", done, 1'b1);
    check("b2b1_product", {hi, lo}, 64'd16);
    mcand  = 32'd5;
    mplier = 32'd5;
    tick();
    start  = 1'b0;
    check("b2b_done_falls", done, 1'b0);
    check("b2b_busy_again", busy, 1'b1);
    check("b2b_lo_held", lo, 32'd16);
    run_to_done(0, n, busy_ok, stable_ok);
    check("b2b2_latency", n, 32);
    check("b2b2_hilo_stable", stable_ok, 1'b1);
    check("b2b2_done", done, 1'b1);
    check("b2b2_product", {hi, lo}, 64'd25);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
